// File: rtl/term_writer.sv
// term_writer: decodes an ASCII byte stream into VGA terminal writes (data/dtype/dstrobe) with a shadow cursor.
// Define ESC_POS_EN to enable ESC row col absolute cursor positioning.
module term_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int STB_CYCLES = 4,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data,
  output logic [1:0] dtype,
  output logic       dstrobe,
  output logic       busy,
  output logic [5:0] cur_row,
  output logic [6:0] cur_col
);
  localparam int TW = $clog2(STB_CYCLES + 1);
  localparam logic [11:0] CELLS = 12'(ROWS * COLS);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  typedef enum logic [1:0] {SQ_NONE, SQ_INIT, SQ_CLR, SQ_POS} seq_t;
  state_t state, state_n;
  seq_t seq;
  logic [2:0] ph;
  logic [11:0] cnt;
  logic [TW-1:0] tcnt;
  logic t_last, accept, seq_go, launch, sq_last, dec_go, esc_busy, pos_start;
  logic [1:0] sq_type, dec_type;
  logic [7:0] sq_data, dec_data, tab_col, pos_row, pos_col;
`ifdef ESC_POS_EN
  logic [1:0] esc_st;
  logic [7:0] esc_row, esc_col;
  assign esc_busy = esc_st != 2'd0;
  assign pos_start = accept && esc_st == 2'd2;
  assign pos_row = esc_row;
  assign pos_col = esc_col;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      esc_st <= 2'd0;
      esc_row <= 8'd0;
      esc_col <= 8'd0;
    end else if (accept) begin
      if (esc_st == 2'd1) begin
        esc_row <= in_data > 8'(ROWS - 1) ? 8'(ROWS - 1) : in_data;
        esc_st <= 2'd2;
      end else if (esc_st == 2'd2) begin
        esc_col <= in_data > 8'(COLS - 1) ? 8'(COLS - 1) : in_data;
        esc_st <= 2'd0;
      end else if (in_data == 8'h1b) begin
        esc_st <= 2'd1;
      end
    end
  end
`else
  assign esc_busy = 1'b0;
  assign pos_start = 1'b0;
  assign pos_row = 8'd0;
  assign pos_col = 8'd0;
`endif
  assign in_ready = state == IDLE && seq == SQ_NONE;
  assign busy = !in_ready;
  assign dstrobe = state == HIGH;
  assign accept = in_valid && in_ready;
  assign t_last = tcnt == TW'(STB_CYCLES - 1);
  assign seq_go = seq != SQ_NONE && (state == IDLE || (state == LOW && t_last));
  assign launch = seq_go || (accept && dec_go);
  assign tab_col = ({1'b0, cur_col} | 8'd7) + 8'd1;
  // Sequence phases: 0 row, 1 col, 2 clear cells, 3 row, 4 col; INIT and POS stop after phase 1
  assign sq_type = ph == 3'd2 ? 2'd0 : (ph == 3'd0 || ph == 3'd3) ? 2'd2 : 2'd1;
  assign sq_data = ph == 3'd2 ? CLEAR_CHAR : seq == SQ_POS ? (ph == 3'd0 ? pos_row : pos_col) : 8'd0;
  assign sq_last = ph == 3'd4 || (seq != SQ_CLR && ph == 3'd1);
  always_comb begin
    dec_go = 1'b0;
    dec_type = 2'd0;
    dec_data = in_data;
    if (esc_busy) begin
      dec_go = 1'b0;
    end else if (in_data >= 8'h20 && in_data <= 8'h7e) begin
      dec_go = 1'b1;
    end else if (in_data == 8'h0d) begin
      dec_go = 1'b1;
      dec_type = 2'd1;
      dec_data = 8'd0;
    end else if (in_data == 8'h0a) begin
      dec_go = 1'b1;
      dec_type = 2'd2;
      dec_data = cur_row == 6'(ROWS - 1) ? 8'd0 : {2'b0, cur_row} + 8'd1;
    end else if (in_data == 8'h08) begin
      dec_go = cur_col != 7'd0;
      dec_type = 2'd1;
      dec_data = {1'b0, cur_col} - 8'd1;
    end else if (in_data == 8'h09) begin
      dec_go = 1'b1;
      dec_type = 2'd1;
      dec_data = tab_col > 8'(COLS - 1) ? 8'(COLS - 1) : tab_col;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = launch ? SETUP : IDLE;
      SETUP:   state_n = HIGH;
      HIGH:    state_n = t_last ? LOW : HIGH;
      LOW:     state_n = t_last ? (seq_go ? SETUP : IDLE) : LOW;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq <= SQ_INIT;
      ph <= 3'd0;
      cnt <= 12'd0;
      tcnt <= '0;
      data <= 8'd0;
      dtype <= 2'd0;
      cur_row <= 6'd0;
      cur_col <= 7'd0;
    end else begin
      tcnt <= (state == HIGH || state == LOW) && !t_last ? tcnt + TW'(1) : '0;
      if (launch) begin
        data <= seq_go ? sq_data : dec_data;
        dtype <= seq_go ? sq_type : dec_type;
      end
      if (seq_go) begin
        seq <= sq_last ? SQ_NONE : seq;
        ph <= sq_last ? 3'd0 : (ph == 3'd2 && cnt != CELLS - 12'd1) ? ph : ph + 3'd1;
        cnt <= ph == 3'd2 ? cnt + 12'd1 : cnt;
      end else if (accept && !esc_busy && in_data == 8'h0c) begin
        seq <= SQ_CLR;
        ph <= 3'd0;
        cnt <= 12'd0;
      end else if (pos_start) begin
        seq <= SQ_POS;
        ph <= 3'd0;
      end
      // SETUP -> HIGH is the strobe's rising edge, where the terminal applies the op
      if (state == SETUP) begin
        if (dtype == 2'd1) begin
          cur_col <= data[6:0];
        end else if (dtype == 2'd2) begin
          cur_row <= data[5:0];
        end else if (cur_col == 7'(COLS - 1)) begin
          cur_col <= 7'd0;
          cur_row <= cur_row == 6'(ROWS - 1) ? 6'd0 : cur_row + 6'd1;
        end else begin
          cur_col <= cur_col + 7'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_term_writer.sv
// tb_term_writer: directed checks of term_writer decode, strobe timing, shadow cursor, clear and reset abort.
module tb_term_writer;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, prev_stb = 1'b0;
  logic [7:0] in_data = 8'd0, data;
  logic [1:0] dtype;
  logic in_ready, dstrobe, busy;
  logic [5:0] cur_row;
  logic [6:0] cur_col;
  logic [9:0] log_q[$];
  int vec = 0, err = 0;

  always #5 clk = ~clk;

  term_writer dut (.clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
                   .data(data), .dtype(dtype), .dstrobe(dstrobe), .busy(busy), .cur_row(cur_row), .cur_col(cur_col));

  always @(negedge clk) begin
    if (dstrobe && !prev_stb) log_q.push_back({dtype, data});
    prev_stb = dstrobe;
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vec++; err++;
      $display("FAIL ready_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, budget);
    end
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready(30000);
    in_data = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({data, dtype, dstrobe, in_ready, busy, cur_row, cur_col} !== {8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 6'd0, 7'd0}) begin
      err++; $display("FAIL reset_values: got d=%h t=%0d s=%0b r=%0b b=%0b row=%0d col=%0d", data, dtype, dstrobe, in_ready, busy, cur_row, cur_col);
    end
    log_q.delete();
    reset = 1'b0;
    wait_ready(100);
    vec++;
    if (log_q.size() != 2) begin err++; $display("FAIL init_count: got %0d strobes, want 2", log_q.size()); end
    else begin
      vec++;
      if (log_q[0] !== {2'd2, 8'd0} || log_q[1] !== {2'd1, 8'd0}) begin
        err++; $display("FAIL init_ops: got %h %h, want 200 100", log_q[0], log_q[1]);
      end
    end
    vec++;
    if ({in_ready, cur_row, cur_col} !== {1'b1, 6'd0, 7'd0}) begin
      err++; $display("FAIL init_state: got r=%0b row=%0d col=%0d, want 1 0 0", in_ready, cur_row, cur_col);
    end
  endtask

  task automatic test_char;
    int hi = 0, first_hi = 0, rdy = 0;
    log_q.delete();
    send(8'h41);
    @(negedge clk);
    vec++;
    if ({dstrobe, dtype, data} !== {1'b0, 2'd0, 8'h41}) begin
      err++; $display("FAIL char_setup: got s=%0b t=%0d d=%h, want 0 0 41", dstrobe, dtype, data);
    end
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      if (dstrobe) begin hi++; if (first_hi == 0) first_hi = k; end
      if (in_ready && rdy == 0) rdy = k;
    end
    vec++;
    if (hi != 4 || first_hi != 2) begin err++; $display("FAIL char_strobe: got %0d high from cycle %0d, want 4 from 2", hi, first_hi); end
    vec++;
    if (rdy != 10) begin err++; $display("FAIL char_ready: got ready at cycle %0d, want 10", rdy); end
    vec++;
    if ({cur_row, cur_col} !== {6'd0, 7'd1} || log_q.size() != 1) begin
      err++; $display("FAIL char_shadow: got row=%0d col=%0d n=%0d, want 0 1 1", cur_row, cur_col, log_q.size());
    end
  endtask

  task automatic test_wrap;
`ifdef ESC_POS_EN
    send(8'h1b); send(8'h1d); send(8'h4f);
`else
    send(8'h0d);
    repeat (29) send(8'h0a);
    repeat (10) send(8'h09);
`endif
    wait_ready(200);
    vec++;
    if ({cur_row, cur_col} !== {6'd29, 7'd79}) begin err++; $display("FAIL wrap_pos: got %0d,%0d want 29,79", cur_row, cur_col); end
    log_q.delete();
    send(8'h42);
    wait_ready(200);
    vec++;
    if (log_q.size() != 1 || log_q[0] !== {2'd0, 8'h42}) begin
      err++; $display("FAIL wrap_op: got n=%0d, want one 042 strobe", log_q.size());
    end
    vec++;
    if ({cur_row, cur_col} !== {6'd0, 7'd0}) begin err++; $display("FAIL wrap_shadow: got %0d,%0d want 0,0", cur_row, cur_col); end
  endtask

  task automatic test_ctrl;
    repeat (5) send(8'h61);
    wait_ready(200);
    log_q.delete();
    send(8'h09);
    wait_ready(200);
    vec++;
    if (log_q.size() != 1 || log_q[0] !== {2'd1, 8'd8} || cur_col !== 7'd8) begin
      err++; $display("FAIL tab: got n=%0d col=%0d, want one 108 and col 8", log_q.size(), cur_col);
    end
    send(8'h0d);
    wait_ready(200);
    log_q.delete();
    send(8'h08);
    @(negedge clk);
    vec++;
    if (in_ready !== 1'b1) begin err++; $display("FAIL bs0_ready: got %0b want 1", in_ready); end
    repeat (12) @(negedge clk);
    vec++;
    if (log_q.size() != 0) begin err++; $display("FAIL bs0_strobe: got %0d strobes, want 0", log_q.size()); end
    repeat (29) send(8'h0a);
    wait_ready(200);
    log_q.delete();
    send(8'h0a);
    wait_ready(200);
    vec++;
    if (log_q.size() != 1 || log_q[0] !== {2'd2, 8'd0} || cur_row !== 6'd0) begin
      err++; $display("FAIL lf_wrap: got n=%0d row=%0d, want one 200 and row 0", log_q.size(), cur_row);
    end
    log_q.delete();
    send(8'h07);
    send(8'h7f);
    send(8'h95);
    repeat (12) @(negedge clk);
    vec++;
    if (log_q.size() != 0) begin err++; $display("FAIL discard: got %0d strobes, want 0", log_q.size()); end
`ifndef ESC_POS_EN
    send(8'h1b);
    send(8'h43);
    wait_ready(200);
    vec++;
    if (log_q.size() != 1 || log_q[0] !== {2'd0, 8'h43}) begin
      err++; $display("FAIL esc_off: got n=%0d, want one 043 strobe", log_q.size());
    end
`endif
    send(8'h0d);
    send(8'h78);
    wait_ready(200);
    log_q.delete();
    send(8'h08);
    wait_ready(200);
    vec++;
    if (log_q.size() != 1 || log_q[0] !== {2'd1, 8'd0} || cur_col !== 7'd0) begin
      err++; $display("FAIL bs1: got n=%0d col=%0d, want one 100 and col 0", log_q.size(), cur_col);
    end
  endtask

  task automatic test_clear;
    int bad = 0;
    send(8'h35);
    wait_ready(200);
    log_q.delete();
    send(8'h0c);
    repeat (50) @(negedge clk);
    vec++;
    if ({in_ready, busy} !== 2'b01) begin err++; $display("FAIL clear_busy: got r=%0b b=%0b want 0 1", in_ready, busy); end
    wait_ready(30000);
    vec++;
    if (log_q.size() != 2404) begin err++; $display("FAIL clear_count: got %0d strobes, want 2404", log_q.size()); end
    else begin
      for (int i = 2; i < 2402; i++) if (log_q[i] !== {2'd0, 8'h20}) bad++;
      vec++;
      if (bad != 0) begin err++; $display("FAIL clear_cells: got %0d bad cell writes, want 0", bad); end
      vec++;
      if ({log_q[0], log_q[1], log_q[2402], log_q[2403]} !== {2'd2, 8'd0, 2'd1, 8'd0, 2'd2, 8'd0, 2'd1, 8'd0}) begin
        err++; $display("FAIL clear_bracket: got %h %h %h %h", log_q[0], log_q[1], log_q[2402], log_q[2403]);
      end
    end
    vec++;
    if ({cur_row, cur_col} !== {6'd0, 7'd0}) begin err++; $display("FAIL clear_shadow: got %0d,%0d want 0,0", cur_row, cur_col); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    log_q.delete();
    send(8'h0c);
    while ((log_q.size() < 102 || !dstrobe) && n < 5000) begin @(negedge clk); n++; end
    vec++;
    if (!dstrobe) begin err++; $display("FAIL mid_timeout: got dstrobe=%0b, want 1 after 100 writes", dstrobe); end
    #2 reset = 1'b1;
    #1;
    vec++;
    if ({dstrobe, in_ready, busy, data} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      err++; $display("FAIL mid_reset: got s=%0b r=%0b b=%0b d=%h, want 0 0 1 00", dstrobe, in_ready, busy, data);
    end
    repeat (2) @(negedge clk);
    log_q.delete();
    reset = 1'b0;
    wait_ready(100);
    vec++;
    if (log_q.size() != 2) begin err++; $display("FAIL mid_init_count: got %0d strobes, want 2", log_q.size()); end
    else begin
      vec++;
      if (log_q[0] !== {2'd2, 8'd0} || log_q[1] !== {2'd1, 8'd0}) begin
        err++; $display("FAIL mid_init_ops: got %h %h, want 200 100", log_q[0], log_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_char();
    test_wrap();
    test_ctrl();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
